// File: rtl/ctrl_frame_decoder.sv
// Controller-frame parser for the UART input path: validates 5-byte frames
// (A5, player, axis, buttons, xor) and drives per-player paddle commands with watchdogs.
//
// state   | meaning
// IDLE    | hunting for the 0xA5 sync byte
// PLAYER  | expecting player id 0x00 or 0x01
// AXIS    | expecting signed stick Y
// BTNS    | expecting button byte (bit0 = start)
// CSUM    | expecting xor of player, axis and buttons
module ctrl_frame_decoder #(
    parameter int DEADZONE      = 16,
    parameter int FRAME_TIMEOUT = 5_000_000,
    parameter int BYTE_TIMEOUT  = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       start_trigger,
    output logic       frame_err,
    output logic [1:0] link_active
);

    localparam int BW = $clog2(BYTE_TIMEOUT + 1);
    localparam int FW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [BW-1:0] BYTE_RELOAD  = BW'(BYTE_TIMEOUT);
    localparam logic [FW-1:0] FRAME_RELOAD = FW'(FRAME_TIMEOUT);
    localparam logic signed [8:0] DZ_POS = 9'(DEADZONE);
    localparam logic signed [8:0] DZ_NEG = 9'(-DEADZONE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PLAYER = 3'd1;
    localparam logic [2:0] S_AXIS   = 3'd2;
    localparam logic [2:0] S_BTNS   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;

    logic [2:0]    state;
    logic          player;
    logic [7:0]    axis;
    logic [7:0]    btns;
    logic [BW-1:0] byte_timer;

    logic [FW-1:0] wd [2];
    logic [1:0]    up_r;
    logic [1:0]    down_r;
    logic [1:0]    start_bit;

    logic              csum_ok;
    logic              commit;
    logic signed [8:0] axis_s;
    logic              cmd_up;
    logic              cmd_down;

    assign csum_ok  = (rx_data == ({7'b0, player} ^ axis ^ btns));
    assign commit   = rx_valid && (state == S_CSUM) && csum_ok;
    assign axis_s   = {axis[7], axis};
    assign cmd_up   = (axis_s < DZ_NEG);
    assign cmd_down = (axis_s > DZ_POS);

    // A byte arriving in the cycle the timer is at zero takes priority over the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            player     <= 1'b0;
            axis       <= '0;
            btns       <= '0;
            byte_timer <= '0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (rx_valid) begin
                byte_timer <= BYTE_RELOAD;
                case (state)
                    S_IDLE: begin
                        if (rx_data == 8'hA5) state <= S_PLAYER;
                    end
                    S_PLAYER: begin
                        if (rx_data[7:1] == 7'd0) begin
                            player <= rx_data[0];
                            state  <= S_AXIS;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_AXIS: begin
                        axis  <= rx_data;
                        state <= S_BTNS;
                    end
                    S_BTNS: begin
                        btns  <= rx_data;
                        state <= S_CSUM;
                    end
                    S_CSUM: begin
                        if (!csum_ok) frame_err <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                if (byte_timer == '0) begin
                    frame_err <= 1'b1;
                    state     <= S_IDLE;
                end else begin
                    byte_timer <= byte_timer - BW'(1);
                end
            end
        end
    end

    // Commit outranks expiry so a frame landing on the last watchdog cycle keeps the link up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd[0]         <= '0;
            wd[1]         <= '0;
            up_r          <= '0;
            down_r        <= '0;
            start_bit     <= '0;
            start_trigger <= 1'b0;
        end else begin
            start_trigger <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (commit && (player == n[0])) begin
                    wd[n]        <= FRAME_RELOAD;
                    up_r[n]      <= cmd_up;
                    down_r[n]    <= cmd_down;
                    start_bit[n] <= btns[0];
                    if (btns[0] && !start_bit[n]) start_trigger <= 1'b1;
                end else if (wd[n] != '0) begin
                    wd[n] <= wd[n] - FW'(1);
                    if (wd[n] == FW'(1)) begin
                        up_r[n]      <= 1'b0;
                        down_r[n]    <= 1'b0;
                        start_bit[n] <= 1'b0;
                    end
                end
            end
        end
    end

    assign p1_up          = up_r[0];
    assign p1_down        = down_r[0];
    assign p2_up          = up_r[1];
    assign p2_down        = down_r[1];
    assign link_active[0] = (wd[0] != '0);
    assign link_active[1] = (wd[1] != '0);

endmodule

// File: doc/ctrl_frame_decoder.md
# ctrl_frame_decoder

Framed-packet controller for the UART input path. It consumes the byte stream from the UART receiver, validates 5-byte controller frames (sync, player, stick axis, buttons, XOR checksum) and converts them into per-player paddle commands plus a start pulse. Per-player watchdogs release a player's paddle commands when that player's frames stop arriving. Its outputs feed the input-mode multiplexer as the controller-mode source.

## Interface
- `DEADZONE`, default 16: stick magnitude (0..127) that must be exceeded before an up/down command is asserted.
- `FRAME_TIMEOUT`, default 5_000_000: cycles (100 ms at 50 MHz) without a valid frame for a player before that player's outputs clear.
- `BYTE_TIMEOUT`, default 50_000: maximum cycles between bytes inside one frame before the parser aborts.
- `clk`  in  1  50 MHz system clock.
- `rst`  in  1  Reset, asynchronous and active-high.
- `rx_valid`  in  1  One-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  Received UART byte.
- `p1_up`, `p1_down`, `p2_up`, `p2_down`  out  1 each  Registered paddle commands.
- `start_trigger`  out  1  One-cycle pulse on a start-button press.
- `frame_err`  out  1  One-cycle pulse on a bad player byte, checksum mismatch or inter-byte timeout.
- `link_active`  out  2  Bit n is high while player n's watchdog is unexpired.

## Operation
- Parser FSM states: IDLE, PLAYER, AXIS, BTNS, CSUM. It advances only on `rx_valid`.
  - IDLE: byte 0xA5 → PLAYER. Any other byte is ignored with no error.
  - PLAYER: 0x00 or 0x01 is latched → AXIS. Any other value → `frame_err`, IDLE.
  - AXIS: latch a signed 8-bit stick Y → BTNS.
  - BTNS: latch a button byte (bit0 = start) → CSUM.
  - CSUM: compare with player ^ axis ^ buttons. Match → commit, IDLE. Mismatch → `frame_err`, IDLE.
- 0xA5 inside a frame is treated as data. There is no mid-frame resync.
- Inter-byte timer reloads to `BYTE_TIMEOUT` on every accepted byte while not in IDLE. If it reaches 0 outside IDLE → `frame_err`, IDLE.
- Commit for player n:
  - Sign-extend axis to 9 bits.
  - up = axis < −DEADZONE.
  - down = axis > +DEADZONE.
  - up and down are never both 1.
  - Reload player n's frame watchdog to `FRAME_TIMEOUT`.
  - `start_trigger` pulses if buttons bit0 = 1 and player n's stored start bit = 0. Then store bit0.
- Frame watchdog per player counts down and saturates at 0. On reaching 0:
  - that player's up/down clear;
  - its stored start bit clears;
  - its `link_active` bit drops.
- The other player is unaffected by a commit or timeout on one player.

## Timing
- Reset values:
  - FSM = IDLE;
  - all paddle outputs 0;
  - `start_trigger` 0, `frame_err` 0;
  - `link_active` 2'b00;
  - both watchdogs 0 (expired);
  - stored start bits 0.
- Commit latency: outputs, `link_active` and `start_trigger` change on the clock edge after the cycle in which the checksum byte's `rx_valid` is high.
- `frame_err` asserts on that same following edge for protocol errors. For an inter-byte timeout it asserts on the edge after the timer reaches 0.
- Watchdog expiry: outputs clear exactly `FRAME_TIMEOUT` cycles after the commit edge.
- Simultaneous events:
  - commit and watchdog expiry for the same player in the same cycle → the commit wins and the watchdog reloads;
  - `rx_valid` in the cycle the inter-byte timer hits 0 → the byte is processed and no timeout occurs.
- `start_trigger` and `frame_err` are never high for more than one consecutive cycle per event.
- Reset asserted mid-frame → all state returns to reset values immediately. The partial frame is discarded.

## Test plan
- Reset, then A5 00 C0 00 C0 → next edge: `p1_up`=1, `p1_down`=0, `link_active`=01. Other outputs 0.
- A5 01 40 01 40, then the same frame again → `p2_down`=1. `start_trigger` is a single one-cycle pulse after the first frame only. A later frame with buttons=00 followed by buttons=01 pulses again.
- Stick at deadzone boundary with `DEADZONE`=16 (A5 00 F0 00 F0, then A5 00 EF 00 EF) → axis −16 gives `p1_up`=0; axis −17 gives `p1_up`=1.
- Bad checksum (A5 00 C0 00 00) and bad player (A5 02 …) → one `frame_err` pulse each. Outputs hold their previous values. The next valid frame is decoded correctly.
- Inter-byte timeout (A5 00, then idle for `BYTE_TIMEOUT`+1 cycles, then 00 C0) → one `frame_err` pulse. The trailing bytes are ignored in IDLE and no outputs change.
- Frame watchdog (reduced `FRAME_TIMEOUT`=100): valid P1 up frame, then silence → `p1_up` and `link_active[0]` clear exactly 100 cycles after the commit. A frame arriving on the expiry cycle keeps them set.
